economy_ctrl: RTL and testbench
===============================

# economy_ctrl

Game economy unit inside the game engine. Owns the player's money, purse (wallet) level and tower charge counter. Arbitrates the ten HUD click strobes (purse upgrade, eight army-deploy buttons, fire) into at most one accepted action per cycle. Drives the money, purse level, upgrade-enable and tower-count values that the top level uses for click qualification and HUD rendering.

## Interface
Parameters:
- START_MONEY, 15'd100, money loaded on game start
- TOWER_MAX, 8'd150, tower charge full value
- PURSE_MAX, 3'd7, highest purse level

Ports:
- clk_25MHz  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle strobe per video frame, same clock domain
- game_init  in  1  one-cycle pulse: a level was selected
- game_over  in  1  level: win or lose reached
- click  in  10  qualified HUD clicks; [0] purse, [8:1] army types 0..7, [9] fire
- slot_free  in  1  army instance table has a free slot
- money  out  15  current money
- purse_level  out  3  current purse level
- able_to_upgrade  out  1  upgrade affordable and level < PURSE_MAX
- tower_cnt  out  8  tower charge
- deploy_valid  out  1  one-cycle pulse: spawn army of deploy_type
- deploy_type  out  3  army type, valid with deploy_valid
- fire_valid  out  1  one-cycle pulse: fire tower cannon

## Operation
- FSM states:
  - IDLE: money = 0, purse_level = 0, tower_cnt = 0, no pulses.
  - RUN
  - FROZEN: all registers hold, no pulses, clicks ignored.
- FSM transitions:
  - IDLE→RUN on game_init: money←START_MONEY, level←0, tower←0.
  - RUN→FROZEN on game_over.
  - FROZEN→IDLE and RUN→RUN-reload on game_init, reloading the same values.
  - game_init outranks game_over in the same cycle.
- Click arbitration:
  - rise = click & ~click_q. click_q is the previous cycle's click, cleared by reset and in IDLE.
  - The lowest set index of rise wins. All other rises in that cycle are dropped, not queued.
  - A held click produces one action only.
- Cost table (army type 0..7): 75, 150, 240, 350, 750, 1500, 2000, 2400.
- Upgrade cost = 100·(L+1). Cap(L) = 1000 + 500·L. Income per frame_tick = L+1, where L = purse_level.
- Accepted actions in RUN. Affordability is re-checked here: money >= cost, regardless of upstream gating.
  - [0]: if level < PURSE_MAX and money >= upgrade cost, subtract the cost and increment the level.
  - [k], k = 1..8: if slot_free and money >= cost(k-1), subtract the cost and pulse deploy_valid with deploy_type = k-1.
  - [9]: if tower_cnt == TOWER_MAX, clear tower_cnt to 0 and pulse fire_valid.
  - Failed checks: no state change, no pulse.
- Money update per cycle (17-bit internal):
  - Step 1: m = money − spend, where spend is 0 if no action is accepted.
  - Step 2: on frame_tick, m += income, using income of the pre-upgrade level.
  - Step 3: money ← min(m, Cap(new level)).
  - Money never wraps and never goes negative.
- Tower: on frame_tick in RUN, increment saturating at TOWER_MAX. A fire in the same cycle wins: tower_cnt = 0, no increment.
- able_to_upgrade is combinational from the registered money and purse_level. It is 0 in IDLE.

## Timing
- All outputs registered except able_to_upgrade.
- Reset values: money 0, purse_level 0, tower_cnt 0, deploy_valid 0, deploy_type 0, fire_valid 0, able_to_upgrade 0, state IDLE.
- Click rise in cycle n → money, level and tower update plus deploy_valid/fire_valid high in cycle n+1, for exactly one cycle.
- deploy_type is 0 when deploy_valid is low.
- game_init in cycle n → RUN with START_MONEY visible in cycle n+1.
- Reset mid-game overrides everything on the next edge. Any pulse in flight is dropped.

## Structure
- Package econ_pkg: scene/state enum, ARMY_COST[8] constant array, and functions upgrade_cost(L), purse_cap(L), income(L), all width-explicit.
- Sub-module click_arbiter: 10-bit edge detect plus lowest-index priority encoder. Outputs hit (1) and idx (4). Has clk_25MHz and rst.

## Test plan
- Reset, then game_init → money = 100, level 0, tower 0. After 10 frame_ticks money = 110, tower = 10.
- money = 100, click[0] rise → next cycle money = 0, level = 1, able_to_upgrade = 0. Next frame_tick money = 2.
- money = 400, click[1] and click[3] rise together, slot_free = 1 → deploy_valid one cycle, deploy_type = 0, money = 325. click[3] held: no second action.
- slot_free = 0, click[2] rise with money = 500 → no pulse, money unchanged.
- Level 0, money = 999 with frame_tick → money = 1000. Subsequent ticks stay at 1000 (cap).
- tower = 150, click[9] rise coincident with frame_tick → fire_valid one cycle, tower = 0. game_over then freezes all values; clicks ignored until game_init.

Source files
------------

// File: rtl/economy_ctrl_pkg.sv
// Shared types and cost/income arithmetic for the game economy unit.
package econ_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } econ_state_t;

   localparam logic [14:0] ARMY_COST [8] = '{
      15'd75, 15'd150, 15'd240, 15'd350, 15'd750, 15'd1500, 15'd2000, 15'd2400
   };

   function automatic logic [16:0] upgrade_cost(input logic [2:0] lvl);
      return 17'd100 * ({14'd0, lvl} + 17'd1);
   endfunction

   function automatic logic [16:0] purse_cap(input logic [2:0] lvl);
      return 17'd1000 + 17'd500 * {14'd0, lvl};
   endfunction

   function automatic logic [16:0] income(input logic [2:0] lvl);
      return {14'd0, lvl} + 17'd1;
   endfunction

endpackage

// File: rtl/economy_ctrl_if.sv
// HUD/engine side signals of the economy unit, plus the FSM state for observation.
interface economy_ctrl_if;
   import econ_pkg::*;

   logic        frame_tick;
   logic        game_init;
   logic        game_over;
   logic [9:0]  click;
   logic        slot_free;
   logic [14:0] money;
   logic [2:0]  purse_level;
   logic        able_to_upgrade;
   logic [7:0]  tower_cnt;
   logic        deploy_valid;
   logic [2:0]  deploy_type;
   logic        fire_valid;
   econ_state_t state;

   // deploy_valid/fire_valid are single-cycle strobes with no ready; the
   // consumer must take them in the cycle they are high or lose them.
   modport master (
      output frame_tick, game_init, game_over, click, slot_free,
      input  money, purse_level, able_to_upgrade, tower_cnt,
             deploy_valid, deploy_type, fire_valid, state
   );

   modport slave (
      input  frame_tick, game_init, game_over, click, slot_free,
      output money, purse_level, able_to_upgrade, tower_cnt,
             deploy_valid, deploy_type, fire_valid, state
   );
endinterface

// File: rtl/economy_ctrl_click_arbiter.sv
// Rising-edge detect on the ten HUD clicks; the lowest rising index wins.
module click_arbiter (
   input  logic       clk_25MHz,
   input  logic       rst,
   input  logic       clear,
   input  logic [9:0] click,
   output logic       hit,
   output logic [3:0] idx
);
   logic [9:0] click_q;
   logic [9:0] rise;

   always_ff @(posedge clk_25MHz) begin
      if (rst || clear) click_q <= '0;
      else              click_q <= click;
   end

   always_comb begin
      rise = click & ~click_q;
      hit  = |rise;
      idx  = 4'd0;
      // Scan downward so the lowest set index is the one left standing.
      for (int i = 9; i >= 0; i--) begin
         if (rise[i]) idx = 4'(i);
      end
   end
endmodule

// File: rtl/economy_ctrl.sv
// Game economy: money, purse level and tower charge, with one accepted HUD action per cycle.
module economy_ctrl
   import econ_pkg::*;
#(
   parameter logic [14:0] START_MONEY = 15'd100,
   parameter logic [7:0]  TOWER_MAX   = 8'd150,
   parameter logic [2:0]  PURSE_MAX   = 3'd7
) (
   input logic            clk_25MHz,
   input logic            rst,
   economy_ctrl_if.slave  bus
);
   econ_state_t state;
   logic [14:0] money;
   logic [2:0]  level;
   logic [7:0]  tower;
   logic        dv, fv;
   logic [2:0]  dt;

   logic        hit;
   logic [3:0]  idx;
   logic        upg_ok, dep_ok, fire_ok;
   logic [2:0]  dep_type, new_level;
   logic [16:0] money17, spend, m, cap;
   logic [14:0] money_next;
   logic [7:0]  tower_next;

   click_arbiter u_arb (
      .clk_25MHz (clk_25MHz),
      .rst       (rst),
      .clear     (state == ST_IDLE),
      .click     (bus.click),
      .hit       (hit),
      .idx       (idx)
   );

   always_comb begin
      upg_ok   = 1'b0;
      dep_ok   = 1'b0;
      fire_ok  = 1'b0;
      spend    = '0;
      money17  = {2'b00, money};
      dep_type = 3'(idx - 4'd1);
      if (state == ST_RUN && hit) begin
         if (idx == 4'd0) begin
            if (level < PURSE_MAX && money17 >= upgrade_cost(level)) begin
               upg_ok = 1'b1;
               spend  = upgrade_cost(level);
            end
         end else if (idx <= 4'd8) begin
            if (bus.slot_free && money17 >= {2'b00, ARMY_COST[dep_type]}) begin
               dep_ok = 1'b1;
               spend  = {2'b00, ARMY_COST[dep_type]};
            end
         end else begin
            fire_ok = (tower == TOWER_MAX);
         end
      end
      // Income uses the level held before this cycle's upgrade; the cap uses the new one.
      m = money17 - spend;
      if (bus.frame_tick) m = m + income(level);
      new_level  = level + {2'b00, upg_ok};
      cap        = purse_cap(new_level);
      money_next = (m > cap) ? cap[14:0] : m[14:0];
      if (fire_ok)                                 tower_next = 8'd0;
      else if (bus.frame_tick && tower < TOWER_MAX) tower_next = tower + 8'd1;
      else                                         tower_next = tower;
   end

   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         state <= ST_IDLE;
         money <= '0;
         level <= '0;
         tower <= '0;
         dv    <= 1'b0;
         dt    <= '0;
         fv    <= 1'b0;
      end else begin
         dv <= 1'b0;
         dt <= '0;
         fv <= 1'b0;
         case (state)
            ST_IDLE: begin
               money <= '0;
               level <= '0;
               tower <= '0;
               if (bus.game_init) begin
                  state <= ST_RUN;
                  money <= START_MONEY;
               end
            end
            ST_RUN: begin
               if (bus.game_init) begin
                  money <= START_MONEY;
                  level <= '0;
                  tower <= '0;
               end else if (bus.game_over) begin
                  state <= ST_FROZEN;
               end else begin
                  money <= money_next;
                  level <= new_level;
                  tower <= tower_next;
                  dv    <= dep_ok;
                  dt    <= dep_ok ? dep_type : 3'd0;
                  fv    <= fire_ok;
               end
            end
            ST_FROZEN: begin
               if (bus.game_init) begin
                  state <= ST_IDLE;
                  money <= '0;
                  level <= '0;
                  tower <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.money           = money;
   assign bus.purse_level     = level;
   assign bus.tower_cnt       = tower;
   assign bus.deploy_valid    = dv;
   assign bus.deploy_type     = dt;
   assign bus.fire_valid      = fv;
   assign bus.state           = state;
   assign bus.able_to_upgrade = (state != ST_IDLE) && (level < PURSE_MAX) &&
                                ({2'b00, money} >= upgrade_cost(level));
endmodule

// File: tb/tb_economy_ctrl.sv
// Directed bench for economy_ctrl: inputs change and outputs are checked on the falling edge.
module tb_economy_ctrl;
   import econ_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int compared   = 0;
   int mismatched = 0;

   economy_ctrl_if bif ();

   economy_ctrl dut (
      .clk_25MHz (clk),
      .rst       (rst),
      .bus       (bif)
   );

   always #20 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      bif.frame_tick = 1'b1;
      repeat (n) cycle();
      bif.frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) cycle();
      compared++; if (bif.money !== 15'd0) begin mismatched++; $display("FAIL reset_money: got %0d want 0", bif.money); end
      compared++; if (bif.purse_level !== 3'd0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", bif.purse_level); end
      compared++; if (bif.tower_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_tower: got %0d want 0", bif.tower_cnt); end
      compared++; if ({bif.deploy_valid, bif.deploy_type, bif.fire_valid} !== 5'b0) begin mismatched++; $display("FAIL reset_pulses: got dv=%b dt=%0d fv=%b want 0", bif.deploy_valid, bif.deploy_type, bif.fire_valid); end
      compared++; if (bif.able_to_upgrade !== 1'b0) begin mismatched++; $display("FAIL reset_able: got %b want 0", bif.able_to_upgrade); end
      compared++; if (bif.state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want IDLE", bif.state); end
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_start();
      bif.game_init = 1'b1; cycle(); bif.game_init = 1'b0;
      compared++; if (bif.state !== ST_RUN) begin mismatched++; $display("FAIL start_state: got %0d want RUN", bif.state); end
      compared++; if (bif.money !== 15'd100) begin mismatched++; $display("FAIL start_money: got %0d want 100", bif.money); end
      compared++; if (bif.able_to_upgrade !== 1'b1) begin mismatched++; $display("FAIL start_able: got %b want 1", bif.able_to_upgrade); end
      ticks(10);
      compared++; if (bif.money !== 15'd110) begin mismatched++; $display("FAIL income_money: got %0d want 110", bif.money); end
      compared++; if (bif.tower_cnt !== 8'd10) begin mismatched++; $display("FAIL income_tower: got %0d want 10", bif.tower_cnt); end
   endtask

   task automatic test_upgrade();
      bif.game_init = 1'b1; cycle(); bif.game_init = 1'b0;
      bif.click = 10'b0000000001; cycle(); bif.click = '0;
      compared++; if (bif.money !== 15'd0) begin mismatched++; $display("FAIL upg_money: got %0d want 0", bif.money); end
      compared++; if (bif.purse_level !== 3'd1) begin mismatched++; $display("FAIL upg_level: got %0d want 1", bif.purse_level); end
      compared++; if (bif.able_to_upgrade !== 1'b0) begin mismatched++; $display("FAIL upg_able: got %b want 0", bif.able_to_upgrade); end
      ticks(1);
      compared++; if (bif.money !== 15'd2) begin mismatched++; $display("FAIL upg_income: got %0d want 2", bif.money); end
   endtask

   task automatic test_deploy();
      ticks(199);
      compared++; if (bif.money !== 15'd400) begin mismatched++; $display("FAIL dep_setup: got %0d want 400", bif.money); end
      bif.slot_free = 1'b1;
      bif.click = 10'b0000001010; cycle();
      compared++; if (bif.deploy_valid !== 1'b1 || bif.deploy_type !== 3'd0) begin mismatched++; $display("FAIL dep_pulse: got dv=%b dt=%0d want dv=1 dt=0", bif.deploy_valid, bif.deploy_type); end
      compared++; if (bif.money !== 15'd325) begin mismatched++; $display("FAIL dep_money: got %0d want 325", bif.money); end
      bif.click = 10'b0000001000; cycle();
      compared++; if (bif.deploy_valid !== 1'b0 || bif.money !== 15'd325) begin mismatched++; $display("FAIL dep_held1: got dv=%b money=%0d want dv=0 money=325", bif.deploy_valid, bif.money); end
      cycle();
      compared++; if (bif.deploy_valid !== 1'b0 || bif.money !== 15'd325) begin mismatched++; $display("FAIL dep_held2: got dv=%b money=%0d want dv=0 money=325", bif.deploy_valid, bif.money); end
      bif.click = '0; cycle();
      bif.click = 10'b0000001000; cycle(); bif.click = '0;
      compared++; if (bif.deploy_valid !== 1'b1 || bif.deploy_type !== 3'd2 || bif.money !== 15'd85) begin mismatched++; $display("FAIL dep_type2: got dv=%b dt=%0d money=%0d want 1/2/85", bif.deploy_valid, bif.deploy_type, bif.money); end
      cycle();
      compared++; if (bif.deploy_valid !== 1'b0 || bif.deploy_type !== 3'd0) begin mismatched++; $display("FAIL dep_clear: got dv=%b dt=%0d want 0/0", bif.deploy_valid, bif.deploy_type); end
   endtask

   task automatic test_no_slot();
      bif.game_init = 1'b1; cycle(); bif.game_init = 1'b0;
      ticks(400);
      compared++; if (bif.money !== 15'd500) begin mismatched++; $display("FAIL noslot_setup: got %0d want 500", bif.money); end
      bif.slot_free = 1'b0;
      bif.click = 10'b0000000100; cycle(); bif.click = '0;
      compared++; if (bif.deploy_valid !== 1'b0 || bif.money !== 15'd500) begin mismatched++; $display("FAIL noslot: got dv=%b money=%0d want dv=0 money=500", bif.deploy_valid, bif.money); end
      bif.slot_free = 1'b1;
   endtask

   task automatic test_cap();
      ticks(499);
      compared++; if (bif.money !== 15'd999) begin mismatched++; $display("FAIL cap_setup: got %0d want 999", bif.money); end
      ticks(1);
      compared++; if (bif.money !== 15'd1000) begin mismatched++; $display("FAIL cap_reach: got %0d want 1000", bif.money); end
      ticks(3);
      compared++; if (bif.money !== 15'd1000) begin mismatched++; $display("FAIL cap_hold: got %0d want 1000", bif.money); end
   endtask

   task automatic test_fire_freeze();
      compared++; if (bif.tower_cnt !== 8'd150) begin mismatched++; $display("FAIL tower_sat: got %0d want 150", bif.tower_cnt); end
      bif.frame_tick = 1'b1; bif.click = 10'b1000000000; cycle();
      bif.frame_tick = 1'b0; bif.click = '0;
      compared++; if (bif.fire_valid !== 1'b1 || bif.tower_cnt !== 8'd0) begin mismatched++; $display("FAIL fire: got fv=%b tower=%0d want 1/0", bif.fire_valid, bif.tower_cnt); end
      cycle();
      compared++; if (bif.fire_valid !== 1'b0) begin mismatched++; $display("FAIL fire_once: got %b want 0", bif.fire_valid); end
      bif.click = 10'b1000000000; cycle(); bif.click = '0;
      compared++; if (bif.fire_valid !== 1'b0) begin mismatched++; $display("FAIL fire_uncharged: got %b want 0", bif.fire_valid); end
      bif.game_over = 1'b1; cycle(); bif.game_over = 1'b0;
      compared++; if (bif.state !== ST_FROZEN) begin mismatched++; $display("FAIL freeze_state: got %0d want FROZEN", bif.state); end
      bif.frame_tick = 1'b1; bif.click = 10'b0000000001; cycle(); cycle();
      bif.frame_tick = 1'b0; bif.click = '0;
      compared++; if (bif.money !== 15'd1000 || bif.purse_level !== 3'd0 || bif.tower_cnt !== 8'd0) begin mismatched++; $display("FAIL freeze_hold: got money=%0d lvl=%0d tower=%0d want 1000/0/0", bif.money, bif.purse_level, bif.tower_cnt); end
      bif.game_init = 1'b1; cycle(); cycle(); bif.game_init = 1'b0;
      compared++; if (bif.state !== ST_RUN || bif.money !== 15'd100) begin mismatched++; $display("FAIL restart: got state=%0d money=%0d want RUN/100", bif.state, bif.money); end
   endtask

   task automatic test_init_priority();
      ticks(1);
      bif.game_init = 1'b1; bif.game_over = 1'b1; cycle();
      bif.game_init = 1'b0; bif.game_over = 1'b0;
      compared++; if (bif.state !== ST_RUN || bif.money !== 15'd100) begin mismatched++; $display("FAIL init_priority: got state=%0d money=%0d want RUN/100", bif.state, bif.money); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; bif.click = 10'b0000000010; cycle();
      rst = 1'b0; bif.click = '0;
      compared++; if (bif.deploy_valid !== 1'b0 || bif.money !== 15'd0 || bif.state !== ST_IDLE) begin mismatched++; $display("FAIL reset_mid: got dv=%b money=%0d state=%0d want 0/0/IDLE", bif.deploy_valid, bif.money, bif.state); end
   endtask

   initial begin
      bif.frame_tick = 1'b0;
      bif.game_init  = 1'b0;
      bif.game_over  = 1'b0;
      bif.click      = '0;
      bif.slot_free  = 1'b1;
      @(negedge clk);
      test_reset();
      test_start();
      test_upgrade();
      test_deploy();
      test_no_slot();
      test_cap();
      test_fire_freeze();
      test_init_priority();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
